// File: rtl/axis_compress_a1.sv
// axis_compress_a1: merges runs of STEP-spaced addresses into {start, length-1} records
// Inverse framing of axis_uncompress_A1; records appear one cycle after the closing beat.
module axis_compress_a1 #(
    parameter int ASIZE   = 16,
    parameter int LSIZE   = 16,
    parameter int STEP    = 1,
    parameter int TIMEOUT = 0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [ASIZE-1:0]       s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [ASIZE+LSIZE-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready
);
    localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    logic [0:0]             state;
    logic [ASIZE-1:0]       start, last;
    logic [LSIZE-1:0]       cnt;
    logic [TW-1:0]          timer;
    logic [ASIZE:0]         next_addr;
    logic                   out_free, contig, hold, accept, flush, expire, ld, ld_last;
    logic [ASIZE+LSIZE-1:0] ld_data;

    // carry-out of next_addr forbids merging across the address wrap
    assign next_addr = {1'b0, last} + (ASIZE+1)'(STEP);
    assign contig    = ~next_addr[ASIZE] && next_addr[ASIZE-1:0] == s_axis_tdata && ~&cnt;
    // a breaking tlast beat needs two records: flush the run first, take the beat next slot
    assign hold      = state == RUN && s_axis_tvalid && s_axis_tlast && ~contig;
    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = out_free & ~hold;
    assign accept    = s_axis_tvalid & s_axis_tready;
    assign flush     = out_free & hold;
    assign expire    = (TIMEOUT > 0) && state == RUN && ~s_axis_tvalid && timer == TW'(TIMEOUT) && out_free;

    always_comb begin
        ld      = 1'b0;
        ld_data = {start, cnt};
        ld_last = 1'b0;
        if (accept && state == IDLE) begin
            ld      = s_axis_tlast;
            ld_data = {s_axis_tdata, {LSIZE{1'b0}}};
            ld_last = 1'b1;
        end else if (accept && contig) begin
            ld      = s_axis_tlast;
            ld_data = {start, cnt + 1'b1};
            ld_last = 1'b1;
        end else if (accept || flush || expire) begin
            ld      = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            start <= '0;
            last  <= '0;
            cnt   <= '0;
            timer <= '0;
        end else begin
            timer <= (state == IDLE || s_axis_tvalid) ? '0 :
                     (timer == TW'(TIMEOUT) ? timer : timer + 1'b1);
            if (accept && contig && state == RUN) begin
                last <= s_axis_tdata;
                cnt  <= cnt + 1'b1;
                if (s_axis_tlast) state <= IDLE;
            end else if (accept && !s_axis_tlast) begin
                start <= s_axis_tdata;
                last  <= s_axis_tdata;
                cnt   <= '0;
                state <= RUN;
            end else if (flush || expire) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (ld) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ld_data;
            m_axis_tlast  <= ld_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_compress_a1.sv
// tb_axis_compress_a1: table vectors, timeout/reset sequences and randomized packets
// checked against a run-grouping reference model, over three parameterisations.
module tb_axis_compress_a1;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0][7:0] s_tdata;
    logic [2:0]      s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
    logic [2:0]      fix_rdy, rbits;
    logic            rnd_rdy;
    logic [15:0]     md0, md2;
    logic [11:0]     md1;

    assign m_tready = rnd_rdy ? rbits : fix_rdy;

    axis_compress_a1 #(.ASIZE(8), .LSIZE(8), .STEP(1), .TIMEOUT(0)) dut_a (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(md0), .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready[0]));
    axis_compress_a1 #(.ASIZE(8), .LSIZE(4), .STEP(1), .TIMEOUT(0)) dut_b (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(md1), .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready[1]));
    axis_compress_a1 #(.ASIZE(8), .LSIZE(8), .STEP(1), .TIMEOUT(8)) dut_c (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tlast(s_tlast[2]), .s_axis_tready(s_tready[2]),
        .m_axis_tdata(md2), .m_axis_tvalid(m_tvalid[2]), .m_axis_tlast(m_tlast[2]), .m_axis_tready(m_tready[2]));

    int          n_cmp = 0, n_fail = 0, cur = 0, got_rd = 0, last_wait = 0;
    int          stab_err = 0, stab_chk = 0;
    logic [16:0] got[$], exp_q[$];
    logic [7:0]  pkt[$];
    logic        pv = 1'b0;
    logic [16:0] pr = '0;

    function automatic logic [15:0] mdat(input int s);
        return s == 1 ? {4'b0, md1} : (s == 2 ? md2 : md0);
    endfunction

    function automatic logic [16:0] rec(input logic l, input int s, input int n, input int lsz);
        return {l, 16'((s << lsz) | n)};
    endfunction

    // a packet is cut into maximal runs of +1 addresses (no wrap, at most 2^lsz long)
    function automatic void model(input int lsz);
        int s = pkt[0];
        int n = 1;
        for (int i = 1; i < pkt.size(); i++)
            if (int'(pkt[i]) == int'(pkt[i-1]) + 1 && n < (1 << lsz)) n++;
            else begin
                exp_q.push_back(rec(1'b0, s, n - 1, lsz));
                s = int'(pkt[i]);
                n = 1;
            end
        exp_q.push_back(rec(1'b1, s, n - 1, lsz));
    endfunction

    initial begin
        rbits = '1;
        forever begin
            @(posedge clk);
            #1 rbits = 3'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) pv <= 1'b0;
        else begin
            if (pv) begin
                stab_chk <= stab_chk + 1;
                if (!m_tvalid[cur] || {m_tlast[cur], mdat(cur)} != pr) stab_err <= stab_err + 1;
            end
            pv <= m_tvalid[cur] && !m_tready[cur];
            pr <= {m_tlast[cur], mdat(cur)};
            if (m_tvalid[cur] && m_tready[cur]) got.push_back({m_tlast[cur], mdat(cur)});
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] a, input logic l, input int gap, output int w);
        w = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_tdata[sel] = a;
        s_tlast[sel] = l;
        s_tvalid[sel] = 1'b1;
        @(negedge clk);
        while (!s_tready[sel] && w < 500) begin
            w++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        if (w == 500) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: dut %0d addr %0h not accepted", sel, a);
        end
        @(posedge clk);
        #1 s_tvalid[sel] = 1'b0;
    endtask

    task automatic send_pkt(input int sel, input bit gaps);
        for (int i = 0; i < pkt.size(); i++)
            send(sel, pkt[i], i == pkt.size() - 1, gaps ? int'($urandom_range(0, 2)) : 0, last_wait);
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (got.size() - got_rd < exp_q.size() && t < 300) begin
            @(posedge clk);
            #1 t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_count"}, 32'(got.size() - got_rd), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size() - got_rd; i++)
            check(nm, 32'(got[got_rd + i]), 32'(exp_q[i]));
        got_rd = got.size();
        exp_q.delete();
    endtask

    typedef struct {
        int sel, a0, n0, a1, n1, hold, nexp, s0, c0, s1, c1;
    } vec_t;
    vec_t tv[5];

    initial begin
        int w, lsz, len;
        logic [7:0] a;
        tv[0] = '{0, 'h0A, 4, 0, 0, 0, 1, 'h0A, 3, 0, 0};
        tv[1] = '{0, 5, 2, 9, 1, 1, 2, 5, 1, 9, 0};
        tv[2] = '{0, 'hFE, 3, 0, 0, 1, 2, 'hFE, 1, 0, 0};
        tv[3] = '{1, 0, 20, 0, 0, 0, 2, 0, 15, 'h10, 3};
        tv[4] = '{0, 1, 3, 7, 2, -1, 2, 1, 2, 7, 1};
        s_tdata = '0;
        s_tvalid = '0;
        s_tlast = '0;
        fix_rdy = '1;
        rnd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_mvalid", 32'(m_tvalid[k]), 0);
            check("reset_mdata_mlast", 32'({m_tlast[k], mdat(k)}), 0);
            check("reset_sready", 32'(s_tready[k]), 1);
        end

        for (int v = 0; v < 5; v++) begin
            lsz = tv[v].sel == 1 ? 4 : 8;
            cur = tv[v].sel;
            pkt.delete();
            for (int i = 0; i < tv[v].n0; i++) pkt.push_back(8'(tv[v].a0 + i));
            for (int i = 0; i < tv[v].n1; i++) pkt.push_back(8'(tv[v].a1 + i));
            exp_q.push_back(rec(tv[v].nexp == 1, tv[v].s0, tv[v].c0, lsz));
            if (tv[v].nexp == 2) exp_q.push_back(rec(1'b1, tv[v].s1, tv[v].c1, lsz));
            if (tv[v].hold < 0) begin
                fix_rdy[cur] = 1'b0;
                fork
                    send_pkt(cur, 1'b0);
                    begin
                        repeat (20) @(posedge clk);
                        #1;
                        check("stall_sready", 32'(s_tready[cur]), 0);
                        check("stall_data", 32'({m_tvalid[cur], m_tlast[cur], mdat(cur)}), 32'({1'b1, exp_q[0]}));
                        fix_rdy[cur] = 1'b1;
                    end
                join
            end else begin
                send_pkt(cur, 1'b0);
                check("hold_cycles", 32'(last_wait), 32'(tv[v].hold));
            end
            check("latency", 32'({m_tvalid[cur], m_tlast[cur], mdat(cur)}), 32'({2'b11, exp_q[exp_q.size() - 1][15:0]}));
            drain("table_rec");
        end

        // timeout flush on the TIMEOUT=8 instance
        cur = 2;
        send(2, 8'h04, 1'b0, 0, w);
        send(2, 8'h05, 1'b0, 0, w);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1 check("timeout_wait", 32'({m_tvalid[2], m_tlast[2], mdat(2)}), k < 9 ? 32'h0 : 32'h20401);
        end
        exp_q.push_back(rec(1'b0, 'h04, 1, 8));
        drain("timeout_rec");

        // reset with an open run and a stalled pending record
        for (int r = 0; r < 3; r++) begin
            fix_rdy[2] = 1'b0;
            send(2, 8'(r * 16 + 4), 1'b0, 0, w);
            send(2, 8'(r * 16 + 5), 1'b0, 0, w);
            send(2, 8'(r * 16 + 9), 1'b0, 0, w);
            check("pre_reset_valid", 32'(m_tvalid[2]), 1);
            rst_n = 1'b0;
            #1 check("reset_async_valid", 32'(m_tvalid[2]), 0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            fix_rdy[2] = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            check("no_rec_after_rst", 32'(got.size() - got_rd), 0);
            check("sready_after_rst", 32'(s_tready[2]), 1);
        end

        for (int sel = 0; sel < 2; sel++) begin
            cur = sel;
            lsz = sel == 1 ? 4 : 8;
            rnd_rdy = 1'b1;
            for (int p = 0; p < 60; p++) begin
                pkt.delete();
                len = int'($urandom_range(1, 24));
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
                for (int i = 0; i < len; i++) begin
                    pkt.push_back(a);
                    a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : a + 8'd1;
                end
                model(lsz);
                send_pkt(sel, 1'b1);
            end
            rnd_rdy = 1'b0;
            drain("random_rec");
        end

        check("stable_while_stalled", 32'(stab_err), 0);
        check("stall_observed", 32'(stab_chk > 0), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
